taus_urng_multi: RTL and testbench
==================================

TAUS_URNG_MULTI -- requirements
Module: taus_urng_multi

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, giving the number of independent Tausworthe channels (legal range 1..8).
REQ-002 The module SHALL have parameter WARMUP_CYC, default 8, giving the state steps discarded after seeding (legal range 1..255).
REQ-003 The module SHALL have parameter CH_W, default 3, giving the width of the channel-index field.
REQ-004 Port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port seed_valid, input, 1 bit: seed word present.
REQ-007 Port seed_ready, output, 1 bit: seed accepted this cycle when seed_valid is also high.
REQ-008 Port seed_ch, input, CH_W bits: target channel index.
REQ-009 Port seed_data, input, 96 bits: seed values, s2 in [95:64], s1 in [63:32], s0 in [31:0].
REQ-010 Port seed_err, output, 1 bit: one-cycle pulse when an accepted seed was corrected or ignored.
REQ-011 Port out_data, output, NUM_CH*32 bits: channel n output in bits [32n+31:32n].
REQ-012 Port out_valid, output, 1 bit: out_data holds a fresh, unconsumed sample set.
REQ-013 Port out_ready, input, 1 bit: consumer accepts out_data when out_valid is also high.

Function
REQ-014 Each channel SHALL hold 32-bit registers s0, s1 and s2.
REQ-015 A step SHALL compute new s0 as ((s0 & FFFFFFFE) << 12) XOR (((s0 << 13) XOR s0) >> 19); all arithmetic is 32-bit and overflow bits are discarded.
REQ-016 A step SHALL compute new s1 as ((s1 & FFFFFFF8) << 4) XOR (((s1 << 2) XOR s1) >> 25).
REQ-017 A step SHALL compute new s2 as ((s2 & FFFFFFF0) << 17) XOR (((s2 << 3) XOR s2) >> 11).
REQ-018 On every step, each channel's out_data word SHALL be registered as new s0 XOR new s1 XOR new s2; all channels step together.
REQ-019 The FSM SHALL have three states: UNSEEDED, WARMUP and RUN.
REQ-020 A per-channel seeded mask SHALL track which channels hold valid seeds.
REQ-021 seed_ready SHALL be 1 in UNSEEDED and RUN, and 0 in WARMUP and during reset.
REQ-022 On seed acceptance with seed_ch < NUM_CH, the selected channel SHALL load s0, s1 and s2 and set its mask bit.
REQ-023 If an accepted seed has s0 < 2, s1 < 8 or s2 < 16, each offending word SHALL be ORed with 2, 8 or 16 respectively before loading, and seed_err SHALL pulse the next cycle.
REQ-024 If an accepted seed has seed_ch >= NUM_CH, no state SHALL change and seed_err SHALL pulse the next cycle.
REQ-025 UNSEEDED SHALL go to WARMUP on the edge where the mask becomes all ones; the warmup counter loads WARMUP_CYC.
REQ-026 In WARMUP, all channels SHALL step once per cycle and the counter SHALL decrement; at count 1 the FSM goes to RUN, giving exactly WARMUP_CYC steps.
REQ-027 On entering RUN, out_valid SHALL be 1; out_valid therefore rises WARMUP_CYC+1 edges after the completing seed acceptance.
REQ-028 In RUN, when out_valid and out_ready are both 1, all channels SHALL step and out_valid SHALL stay 1, giving back-to-back samples at one set per cycle.
REQ-029 In RUN, when out_ready is 0, the state and out_data SHALL hold stable.
REQ-030 A seed accepted in RUN SHALL reseed its channel, drop out_valid the next cycle, and re-enter WARMUP; the coincident handshake is honoured, with the seed load taking priority over the step for that channel.
REQ-031 No step SHALL occur in UNSEEDED; out_valid SHALL be 0 outside RUN.

Reset
REQ-032 While reset is 1 at a rising edge: state goes to UNSEEDED, mask, all s0/s1/s2, counter and out_data to 0, and out_valid, seed_err and seed_ready to 0.
REQ-033 Reset SHALL override any concurrent seed or output handshake, including a reset issued mid-WARMUP or mid-RUN.
REQ-034 seed_ready SHALL return to 1 on the first cycle after reset is released.

Verification
REQ-035 Seed all 4 channels with distinct legal seeds (e.g. s0=12345678h, s1=9ABCDEF0h, s2=0FEDCBA9h, channel index XORed into s0) -> out_valid rises exactly 9 edges after the last acceptance; 1000 samples per channel match a bit-exact golden model including the 8 discarded steps.
REQ-036 Seed channel 0 with s0=1, s1=3, s2=0 -> seed_err pulses once and loaded values are 3, 11, 16.
REQ-037 Seed with seed_ch=5 when NUM_CH=4 -> seed_err pulses, mask unchanged, FSM stays UNSEEDED.
REQ-038 In RUN, hold out_ready=0 for 10 cycles, then 1 -> out_data stable for 10 cycles, then one new sample set per cycle.
REQ-039 Reseed channel 2 in RUN during an active handshake -> out_valid 0 for 8 cycles; channels 0, 1 and 3 continue the golden sequence.
REQ-040 Assert reset mid-WARMUP -> all outputs 0 next cycle and seed_ready 1 after release.

Source files
------------

// File: rtl/taus_urng_multi.sv
// Multi-channel taus88 uniform RNG: per-channel seed load with legality fix-up,
// fixed warmup discard, then a valid/ready stream of NUM_CH 32-bit samples per set.
module taus_urng_multi #(
  parameter int NUM_CH     = 4,
  parameter int WARMUP_CYC = 8,
  parameter int CH_W       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  seed_valid,
  output logic                  seed_ready,
  input  logic [CH_W-1:0]       seed_ch,
  input  logic [95:0]           seed_data,
  output logic                  seed_err,
  output logic [NUM_CH*32-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  function automatic logic [31:0] step_s0(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] step_s1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] step_s2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        warm_cnt;
  logic [7:0]        warm_cnt_nxt;
  logic [NUM_CH-1:0] seeded;
  logic [NUM_CH-1:0] seeded_nxt;
  logic [NUM_CH-1:0] load_ch;

  logic [31:0] s0_q   [NUM_CH];
  logic [31:0] s1_q   [NUM_CH];
  logic [31:0] s2_q   [NUM_CH];
  logic [31:0] out_q  [NUM_CH];
  logic [31:0] s0_stp [NUM_CH];
  logic [31:0] s1_stp [NUM_CH];
  logic [31:0] s2_stp [NUM_CH];

  logic [31:0] seed_s0;
  logic [31:0] seed_s1;
  logic [31:0] seed_s2;
  logic        seed_fix;
  logic        ch_ok;
  logic        seed_acc;
  logic        seed_load;
  logic        step_en;
  logic        out_valid_nxt;
  logic        seed_err_nxt;

  // Degenerate taus88 seeds (too few significant bits) are forced legal.
  always_comb begin
    seed_s0  = seed_data[31:0];
    seed_s1  = seed_data[63:32];
    seed_s2  = seed_data[95:64];
    seed_fix = 1'b0;
    if (seed_data[31:0] < 32'd2) begin
      seed_s0  = seed_data[31:0] | 32'd2;
      seed_fix = 1'b1;
    end
    if (seed_data[63:32] < 32'd8) begin
      seed_s1  = seed_data[63:32] | 32'd8;
      seed_fix = 1'b1;
    end
    if (seed_data[95:64] < 32'd16) begin
      seed_s2  = seed_data[95:64] | 32'd16;
      seed_fix = 1'b1;
    end
  end

  always_comb begin
    ch_ok        = 32'(seed_ch) < 32'(NUM_CH);
    seed_acc     = seed_valid && seed_ready;
    seed_load    = seed_acc && ch_ok;
    seed_err_nxt = seed_acc && (!ch_ok || seed_fix);
    load_ch      = '0;
    seeded_nxt   = seeded;
    for (int n = 0; n < NUM_CH; n++) begin
      load_ch[n] = seed_load && (32'(seed_ch) == 32'(n));
      if (load_ch[n]) begin
        seeded_nxt[n] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      s0_stp[n] = step_s0(s0_q[n]);
      s1_stp[n] = step_s1(s1_q[n]);
      s2_stp[n] = step_s2(s2_q[n]);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_UNSEEDED;
      warm_cnt <= 8'd0;
      seeded   <= '0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
      seeded   <= seeded_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    case (state)
      ST_UNSEEDED: begin
        if (seed_load && (&seeded_nxt)) begin
          state_nxt    = ST_WARMUP;
          warm_cnt_nxt = 8'(WARMUP_CYC);
        end
      end
      ST_WARMUP: begin
        warm_cnt_nxt = warm_cnt - 8'd1;
        if (warm_cnt == 8'd1) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (seed_load) begin
          state_nxt    = ST_WARMUP;
          warm_cnt_nxt = 8'(WARMUP_CYC);
        end
      end
      default: begin
        state_nxt    = ST_UNSEEDED;
        warm_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Output / control decode
  always_comb begin
    seed_ready    = !reset && (state != ST_WARMUP);
    step_en       = (state == ST_WARMUP) ||
                    ((state == ST_RUN) && out_valid && out_ready);
    out_valid_nxt = (state_nxt == ST_RUN);
  end

  // A seed load wins over a coincident step for its own channel only.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      seed_err  <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        s0_q[n]  <= 32'd0;
        s1_q[n]  <= 32'd0;
        s2_q[n]  <= 32'd0;
        out_q[n] <= 32'd0;
      end
    end else begin
      out_valid <= out_valid_nxt;
      seed_err  <= seed_err_nxt;
      for (int n = 0; n < NUM_CH; n++) begin
        if (load_ch[n]) begin
          s0_q[n] <= seed_s0;
          s1_q[n] <= seed_s1;
          s2_q[n] <= seed_s2;
        end else if (step_en) begin
          s0_q[n]  <= s0_stp[n];
          s1_q[n]  <= s1_stp[n];
          s2_q[n]  <= s2_stp[n];
          out_q[n] <= s0_stp[n] ^ s1_stp[n] ^ s2_stp[n];
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      out_data[32*n +: 32] = out_q[n];
    end
  end

endmodule

// File: tb/tb_taus_urng_multi.sv
// Directed/randomized bench for taus_urng_multi against a per-channel taus88 reference.
module tb_taus_urng_multi;

  localparam int NUM_CH = 4;
  localparam int WARM   = 8;
  localparam int CH_W   = 3;

  logic              clk;
  logic              reset;
  logic              seed_valid;
  logic              seed_ready;
  logic [CH_W-1:0]   seed_ch;
  logic [95:0]       seed_data;
  logic              seed_err;
  logic [NUM_CH*32-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  int vectors     = 0;
  int miscompares = 0;
  int edges;
  int lows;

  // Reference state: ms[channel][component]
  int unsigned ms [NUM_CH][3];

  taus_urng_multi #(.NUM_CH(NUM_CH), .WARMUP_CYC(WARM), .CH_W(CH_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_ch    (seed_ch),
    .seed_data  (seed_data),
    .seed_err   (seed_err),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One taus88 component recurrence, selected by k.
  function automatic int unsigned comp_step(input int unsigned s, input int k);
    int unsigned msk;
    int shl, q, shr;
    case (k)
      0:       begin msk = 32'hFFFFFFFE; shl = 12; q = 13; shr = 19; end
      1:       begin msk = 32'hFFFFFFF8; shl = 4;  q = 2;  shr = 25; end
      default: begin msk = 32'hFFFFFFF0; shl = 17; q = 3;  shr = 11; end
    endcase
    return ((s & msk) << shl) ^ (((s << q) ^ s) >> shr);
  endfunction

  function automatic logic [95:0] legal_seed(input int n);
    return {32'h0FEDCBA9, 32'h9ABCDEF0, 32'h12345678 ^ 32'(n)};
  endfunction

  function automatic logic [NUM_CH*32-1:0] exp_vec();
    logic [NUM_CH*32-1:0] v;
    for (int n = 0; n < NUM_CH; n++)
      v[32*n +: 32] = ms[n][0] ^ ms[n][1] ^ ms[n][2];
    return v;
  endfunction

  task automatic step_ch(input int n);
    for (int k = 0; k < 3; k++) ms[n][k] = comp_step(ms[n][k], k);
  endtask

  task automatic step_all(input int times);
    for (int t = 0; t < times; t++)
      for (int n = 0; n < NUM_CH; n++) step_ch(n);
  endtask

  task automatic load_model(input int n, input logic [95:0] d);
    ms[n][0] = d[31:0];
    ms[n][1] = d[63:32];
    ms[n][2] = d[95:64];
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input int ch, input logic [95:0] d);
    seed_valid = 1'b1;
    seed_ch    = CH_W'(ch);
    seed_data  = d;
    tick();
    seed_valid = 1'b0;
  endtask

  // Counts edges from the (already taken) acceptance edge until out_valid.
  task automatic wait_valid(output int e);
    e = 1;
    while (!out_valid && e < 40) begin
      tick();
      e++;
    end
  endtask

  task automatic run_samples(input int n_hs, input int ready_pct);
    int hs  = 0;
    int cyc = 0;
    while (hs < n_hs && cyc < 20 * n_hs) begin
      check("out_valid_run", out_valid, 1'b1);
      check("sample", out_data, exp_vec());
      out_ready = ($urandom_range(99) < ready_pct);
      tick();
      if (out_ready) begin
        step_all(1);
        hs++;
      end
      cyc++;
    end
    out_ready = 1'b0;
    check("handshake_budget", hs, n_hs);
  endtask

  initial begin
    reset      = 1'b1;
    seed_valid = 1'b0;
    seed_ch    = '0;
    seed_data  = '0;
    out_ready  = 1'b0;
    #1;
    check("seed_ready_in_reset", seed_ready, 1'b0);
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_seed_err", seed_err, 1'b0);
    reset = 1'b0;
    #1;
    check("seed_ready_after_rst", seed_ready, 1'b1);

    // Out-of-range channel is ignored but flagged
    do_seed(5, legal_seed(5));
    check("bad_ch_err", seed_err, 1'b1);
    check("bad_ch_ready", seed_ready, 1'b1);
    check("bad_ch_valid", out_valid, 1'b0);
    tick();
    check("bad_ch_err_pulse_end", seed_err, 1'b0);

    // Channel 0 gets a degenerate seed that must be corrected to 3, 11, 16
    do_seed(0, {32'd0, 32'd3, 32'd1});
    check("fix_err", seed_err, 1'b1);
    ms[0][0] = 3;
    ms[0][1] = 11;
    ms[0][2] = 16;
    for (int n = 1; n < 3; n++) begin
      do_seed(n, legal_seed(n));
      load_model(n, legal_seed(n));
      check("legal_err", seed_err, 1'b0);
      check("partial_mask_ready", seed_ready, 1'b1);
    end
    do_seed(3, legal_seed(3));
    load_model(3, legal_seed(3));
    check("warmup_ready", seed_ready, 1'b0);
    wait_valid(edges);
    check("warmup_latency_a", edges, 9);
    step_all(WARM);
    run_samples(20, 100);

    // Reset in RUN with concurrent handshakes
    out_ready  = 1'b1;
    seed_valid = 1'b1;
    seed_ch    = '0;
    reset      = 1'b1;
    tick();
    check("rst_run_valid", out_valid, 1'b0);
    check("rst_run_data", out_data, '0);
    check("rst_run_ready", seed_ready, 1'b0);
    seed_valid = 1'b0;
    out_ready  = 1'b0;
    reset      = 1'b0;
    #1;
    check("rst_run_ready_rel", seed_ready, 1'b1);

    // Reset mid-WARMUP
    for (int n = 0; n < NUM_CH; n++) do_seed(n, legal_seed(n));
    tick();
    tick();
    tick();
    seed_valid = 1'b1;
    out_ready  = 1'b1;
    reset      = 1'b1;
    tick();
    check("rst_warm_valid", out_valid, 1'b0);
    check("rst_warm_data", out_data, '0);
    check("rst_warm_err", seed_err, 1'b0);
    check("rst_warm_ready", seed_ready, 1'b0);
    seed_valid = 1'b0;
    out_ready  = 1'b0;
    reset      = 1'b0;
    #1;
    check("rst_warm_ready_rel", seed_ready, 1'b1);
    for (int i = 0; i < 12; i++) tick();
    check("mask_cleared_no_valid", out_valid, 1'b0);

    // Full legal seeding, long randomized sample run
    for (int n = 0; n < NUM_CH; n++) begin
      do_seed(n, legal_seed(n));
      load_model(n, legal_seed(n));
    end
    wait_valid(edges);
    check("warmup_latency_b", edges, 9);
    step_all(WARM);
    run_samples(1000, 70);

    // Ten-cycle stall: data must hold, then one new set per cycle
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", out_data, exp_vec());
    end
    run_samples(10, 100);

    // Reseed channel 2 while a handshake is taking place
    check("pre_reseed_valid", out_valid, 1'b1);
    out_ready  = 1'b1;
    seed_valid = 1'b1;
    seed_ch    = CH_W'(2);
    seed_data  = {32'h2468ACE0, 32'h13572468, 32'hAAAA5555};
    tick();
    seed_valid = 1'b0;
    for (int n = 0; n < NUM_CH; n++)
      if (n != 2) step_ch(n);
    load_model(2, {32'h2468ACE0, 32'h13572468, 32'hAAAA5555});
    check("reseed_err", seed_err, 1'b0);
    lows = 0;
    while (!out_valid && lows < 30) begin
      lows++;
      tick();
    end
    check("reseed_low_cycles", lows, 8);
    step_all(WARM);
    run_samples(50, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
